// File: rtl/progmem_loader.sv
// progmem_loader: holds core0 in reset while packing a byte stream into program memory words
module progmem_loader #(
  parameter int WORD_MAG = 5,
  parameter int PROGRAM_ADDR_WIDTH = 5,
  localparam int WORD_WIDTH = 1 << WORD_MAG,
  localparam int BYTES = WORD_WIDTH / 8,
  localparam int WADDR_WIDTH = PROGRAM_ADDR_WIDTH - (WORD_MAG - 3),
  localparam int MAX_WORDS = 1 << WADDR_WIDTH,
  localparam int BI_W = (WORD_MAG > 3) ? WORD_MAG - 3 : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   core_hold,
  output logic [WADDR_WIDTH-1:0] progmem_write_addr,
  output logic [WORD_WIDTH-1:0]  progmem_write_value,
  output logic                   progmem_we,
  output logic                   busy,
  output logic                   error
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, WRITE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [WADDR_WIDTH:0] word_idx_q, word_idx_d;
  logic [BI_W-1:0] byte_idx_q, byte_idx_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d, value_q, value_d;
  logic [WADDR_WIDTH-1:0] addr_q, addr_d;
  logic [16:0] n_hdr;
  logic take, last_byte;
  // next-state, datapath and status outputs; outputs depend only on state, never on byte_valid
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d = buf_q;
    value_d = value_q;
    addr_d = addr_q;
    byte_ready = state_q inside {HDR0, HDR1, LOAD};
    progmem_we = state_q == WRITE;
    core_hold = state_q != DONE;
    busy = state_q inside {HDR0, HDR1, LOAD, WRITE};
    error = state_q == ERR;
    progmem_write_addr = addr_q;
    progmem_write_value = value_q;
    take = byte_valid && byte_ready;
    n_hdr = {1'b0, byte_data, n_q[7:0]};
    last_byte = byte_idx_q == BI_W'(BYTES - 1);
    case (state_q)
      IDLE, DONE, ERR: state_d = start ? HDR0 : state_q;
      HDR0: if (take) begin
        n_d[7:0] = byte_data;
        state_d = HDR1;
      end
      HDR1: if (take) begin
        n_d[15:8] = byte_data;
        word_idx_d = '0;
        byte_idx_d = '0;
        state_d = (n_hdr == 17'd0) ? DONE : (n_hdr > 17'(MAX_WORDS)) ? ERR : LOAD;
      end
      LOAD: if (take) begin
        for (int j = 0; j < BYTES; j++)
          if (byte_idx_q == BI_W'(j)) buf_d[8*j +: 8] = byte_data;
        byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
        if (last_byte) begin
          state_d = WRITE;
          addr_d = word_idx_q[WADDR_WIDTH-1:0];
          value_d = buf_d;
        end
      end
      WRITE: begin
        state_d = (16'(word_idx_q) + 16'd1 == n_q) ? DONE : LOAD;
        word_idx_d = word_idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      buf_q <= '0;
      value_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q <= buf_d;
      value_q <= value_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: tb/tb_progmem_loader.sv
// tb_progmem_loader: randomized stream loads checked against a header/payload reference model
module tb_progmem_loader;
  localparam int MAXW = 8;
  logic clk = 0, reset = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, core_hold, progmem_we, busy, error;
  logic [2:0] progmem_write_addr;
  logic [31:0] progmem_write_value;
  int n_checks = 0, n_fails = 0;
  logic [34:0] wr_q[$];
  logic [7:0] acc_q[$];
  logic [7:0] stim[$];

  progmem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .core_hold(core_hold), .progmem_write_addr(progmem_write_addr),
    .progmem_write_value(progmem_write_value), .progmem_we(progmem_we), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (progmem_we) wr_q.push_back({progmem_write_addr, progmem_write_value});
    if (reset && byte_valid && byte_ready) acc_q.push_back(byte_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 0;
    if (gap > 0) tick(gap);
    byte_valid = 1;
    byte_data = b;
    t = 0;
    @(negedge clk);
    while (!byte_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!byte_ready) check("ready_timeout", byte_ready, 1);
    @(posedge clk);
    #1 byte_valid = 0;
    byte_data = 8'($urandom);
  endtask

  task automatic set_stream(input int n, input int words);
    logic [15:0] h;
    h = 16'(n);
    stim.delete();
    stim.push_back(h[7:0]);
    stim.push_back(h[15:8]);
    for (int i = 0; i < 4 * words; i++) stim.push_back(8'($urandom));
  endtask

  task automatic run_load(input string name, input int maxgap, input bit mid_start);
    int n;
    bit err;
    logic [34:0] exp_q[$];
    n = {stim[1], stim[0]};
    err = n > MAXW;
    for (int k = 0; !err && k < n; k++)
      exp_q.push_back({3'(k), stim[2+4*k+3], stim[2+4*k+2], stim[2+4*k+1], stim[2+4*k]});
    wr_q.delete();
    acc_q.delete();
    pulse_start();
    foreach (stim[i]) begin
      send_byte(stim[i], $urandom_range(0, maxgap));
      if (mid_start && i == 3) pulse_start();
    end
    @(negedge clk);
    if (err) begin
      check({name, "_err_lat"}, error, 1);
      check({name, "_err_hold"}, core_hold, 1);
    end else if (n == 0) begin
      check({name, "_empty_hold"}, core_hold, 0);
    end else begin
      check({name, "_we_lat"}, progmem_we, 1);
      check({name, "_hold_lat1"}, core_hold, 1);
      @(negedge clk);
      check({name, "_hold_lat2"}, core_hold, 0);
      check({name, "_we_once"}, progmem_we, 0);
    end
    tick(1);
    for (int t = 0; busy && t < 20; t++) tick(1);
    tick(2);
    check({name, "_busy"}, busy, 0);
    check({name, "_error"}, error, err);
    check({name, "_hold"}, core_hold, err);
    check({name, "_nwr"}, wr_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) check({name, "_wr"}, wr_q[k], exp_q[k]);
    check({name, "_nacc"}, acc_q.size(), stim.size());
    for (int k = 0; k < stim.size() && k < acc_q.size(); k++) check({name, "_acc"}, acc_q[k], stim[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_valid = 1;
    byte_data = 8'hA5;
    tick(3);
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_hold", core_hold, 1);
      check("rst_ready", byte_ready, 0);
      check("rst_we", progmem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
    end
    check("rst_addr", progmem_write_addr, 0);
    check("rst_value", progmem_write_value, 0);
    tick(1);
    byte_valid = 0;

    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("t2", 0, 0);

    stim = '{8'h09, 8'h00};
    run_load("t3_err", 0, 0);
    set_stream(1, 1);
    run_load("t3_ok", 0, 0);

    stim = '{8'h00, 8'h00};
    run_load("t4", 0, 0);

    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("t5", 5, 0);

    set_stream(MAXW, MAXW);
    run_load("max", 2, 0);

    wr_q.delete();
    pulse_start();
    set_stream(2, 2);
    for (int i = 0; i < 5; i++) send_byte(stim[i], 0);
    pulse_start();
    @(negedge clk);
    check("t6_busy", busy, 1);
    check("t6_ready", byte_ready, 1);
    tick(1);
    reset = 0;
    tick(1);
    reset = 1;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_hold", core_hold, 1);
    check("t6_rst_value", progmem_write_value, 0);
    check("t6_rst_nwr", wr_q.size(), 0);
    tick(1);
    stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("t6", 2, 1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, MAXW + 2);
      set_stream(n, (n > MAXW) ? 0 : n);
      run_load("rnd", 3, r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
